// File: rtl/fifo_rd_pkg.sv
// fifo_rd_pkg: shared state encoding and buffer depth for the FIFO stream reader.
package fifo_rd_pkg;
  localparam int DEPTH = 2;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;
endpackage

// File: rtl/fifo_rd_skid.sv
// fifo_rd_skid: two-entry in-order buffer between FIFO read data and the stream port.
module fifo_rd_skid
  import fifo_rd_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic [1:0]            occ
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic rd_ptr, wr_ptr;
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= din;
  always_ff @(posedge clk) begin
    if (rst) begin
      occ    <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else begin
      occ    <= occ + 2'(push) - 2'(pop);
      rd_ptr <= rd_ptr ^ pop;
      wr_ptr <= wr_ptr ^ push;
    end
  end
endmodule

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: issues FIFO reads and presents words as a valid/ready stream.
// Define FIFO_RD_CNT_EN to add the word_cnt delivered-word counter port.
module fifo_stream_reader
  import fifo_rd_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  empty,
  output logic                  r_en,
  input  logic [DATA_WIDTH-1:0] data_out,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  idle
`ifdef FIFO_RD_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0]  word_cnt
`endif
);
  state_t     state, state_n;
  logic       infl, pop;
  logic [1:0] occ;
  assign m_valid = occ != 2'd0;
  assign pop     = m_valid && m_ready;
  assign idle    = state == IDLE;
  // Buffered plus in-flight words, less the one leaving now, must leave room for the new read.
  assign r_en = !rst && en && !empty && state != DRAIN &&
                (3'(occ) + 3'(infl) - 3'(pop) < 3'(DEPTH));
  always_comb
    state_n = (state == IDLE) ? (en ? RUN : IDLE) :
              en ? RUN : ((occ != 2'd0 || infl) ? DRAIN : IDLE);
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      infl  <= 1'b0;
    end else begin
      state <= state_n;
      infl  <= r_en;
    end
  end
  fifo_rd_skid #(.DATA_WIDTH(DATA_WIDTH)) u_skid (
    .clk (clk),
    .rst (rst),
    .push(infl),
    .pop (pop),
    .din (data_out),
    .dout(m_data),
    .occ (occ)
  );
`ifdef FIFO_RD_CNT_EN
  always_ff @(posedge clk)
    if (rst) word_cnt <= '0;
    else if (pop) word_cnt <= word_cnt + 1'b1;
`endif
endmodule
